// File: rtl/uart_csr_pkg.sv
// Shared address map, STATUS/CTRL bit positions and status layout for uart_csr_mm.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_csr_pkg;

    // Word addresses of the mapped registers; scratch runs from ADDR_SCRATCH0 to NUM_REGS-1
    localparam int ADDR_TXDATA   = 0;
    localparam int ADDR_STATUS   = 1;
    localparam int ADDR_RXDATA   = 2;
    localparam int ADDR_CTRL     = 3;
    localparam int ADDR_SCRATCH0 = 4;

    // STATUS bit positions
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_AVAIL   = 1;
    localparam int ST_RX_OVERRUN = 2;

    // CTRL bit positions
    localparam int CTRL_IE_RX    = 0;
    localparam int CTRL_IE_TX    = 1;

    // Packed so that the member order maps straight onto STATUS[2:0]
    typedef struct packed {
        logic rx_overrun;
        logic rx_avail;
        logic tx_busy;
    } status_t;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry TX holding register between the CSR write port and the UART TX datapath.
// Latency: load at edge N presents valid_o/data_o after edge N.
// Backpressure: accept_o low while full and the consumer is not taking the byte this cycle.
module uart_tx_hold
    import uart_csr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              accept_o,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // A new byte can replace the held one in the same cycle the consumer takes it
    assign accept_o = ~valid_q | ready_i;
    assign full_o   = valid_q;
    assign data_o   = data_q;
    assign valid_o  = valid_q;

    // Load wins over drain; otherwise drop valid once the consumer accepts
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_csr_mm.sv
// Avalon-MM CSR bank for the UART: TX holding reg, RX capture with sticky overrun, STATUS, CTRL, scratch, irq.
// Latency: reads return one cycle after acceptance with readdatavalid; irq_o lags its cause by one cycle.
// Backpressure: waitrequest only for a TXDATA write while the holding reg is full with no handshake; UART_CSR_IRQ_EN enables irq_o.
module uart_csr_mm
    import uart_csr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 10,
    parameter int ADDR_W   = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [DATA_W-1:0] avs_writedata_i,
    output logic              avs_waitrequest_o,
    output logic [DATA_W-1:0] avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              irq_o
);

    // Scratch storage is sized to at least one entry so NUM_REGS == 4 still elaborates
    localparam int NUM_SCR = (NUM_REGS > ADDR_SCRATCH0) ? NUM_REGS - ADDR_SCRATCH0 : 1;

    logic              sel_tx, sel_st, sel_rx, sel_ctrl;
    logic              wr_acc, rd_acc, tx_load, tx_accept, tx_full;
    logic              rx_rd_clr, ovr_set, ovr_clr;
    logic              rx_avail_q, rx_ovr_q;
    logic [DATA_W-1:0] rx_data_q, ctrl_q, rd_data_c, rdata_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] scratch_q [NUM_SCR];
    status_t           status_c;

    assign sel_tx   = (avs_address_i == ADDR_W'(ADDR_TXDATA));
    assign sel_st   = (avs_address_i == ADDR_W'(ADDR_STATUS));
    assign sel_rx   = (avs_address_i == ADDR_W'(ADDR_RXDATA));
    assign sel_ctrl = (avs_address_i == ADDR_W'(ADDR_CTRL));

    // Only a TXDATA write into a full holding register with no drain this cycle stalls
    assign avs_waitrequest_o = avs_write_i & sel_tx & ~tx_accept;
    assign wr_acc  = avs_write_i & ~avs_waitrequest_o;
    // A simultaneous write takes the slot; the read is silently dropped
    assign rd_acc  = avs_read_i & ~avs_write_i;
    assign tx_load = wr_acc & sel_tx;

    assign rx_rd_clr = rd_acc & sel_rx;
    assign ovr_set   = rx_valid_i & rx_avail_q & ~rx_rd_clr;
    assign ovr_clr   = wr_acc & sel_st & avs_writedata_i[ST_RX_OVERRUN];

    assign status_c.tx_busy    = tx_full;
    assign status_c.rx_avail   = rx_avail_q;
    assign status_c.rx_overrun = rx_ovr_q;

    uart_tx_hold #(.DATA_W(DATA_W)) u_tx_hold (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .load_i      (tx_load),
        .load_data_i (avs_writedata_i),
        .accept_o    (tx_accept),
        .full_o      (tx_full),
        .data_o      (tx_data_o),
        .valid_o     (tx_valid_o),
        .ready_i     (tx_ready_i)
    );

    // RX capture: a new byte always lands; an unread byte being overwritten marks overrun (set beats W1C)
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_data_q  <= '0;
            rx_avail_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            if (rx_valid_i) begin
                rx_data_q  <= rx_data_i;
                rx_avail_q <= 1'b1;
            end else if (rx_rd_clr) begin
                rx_avail_q <= 1'b0;
            end
            rx_ovr_q <= ovr_set | (rx_ovr_q & ~ovr_clr);
        end
    end

    // CTRL and scratch writes
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ctrl_q <= '0;
            for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= '0;
        end else if (wr_acc) begin
            if (sel_ctrl) ctrl_q <= avs_writedata_i;
            for (int i = 0; i < NUM_REGS - ADDR_SCRATCH0; i++) begin
                if (avs_address_i == ADDR_W'(ADDR_SCRATCH0 + i)) scratch_q[i] <= avs_writedata_i;
            end
        end
    end

    // Read mux; unmapped and write-only addresses read as zero
    always_comb begin
        rd_data_c = '0;
        if (sel_st)   rd_data_c = DATA_W'(status_c);
        if (sel_rx)   rd_data_c = rx_data_q;
        if (sel_ctrl) rd_data_c = ctrl_q;
        for (int i = 0; i < NUM_REGS - ADDR_SCRATCH0; i++) begin
            if (avs_address_i == ADDR_W'(ADDR_SCRATCH0 + i)) rd_data_c = scratch_q[i];
        end
    end

    // Fixed one-cycle read response
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= rd_data_c;
        end
    end

    assign avs_readdata_o      = rdata_q;
    assign avs_readdatavalid_o = rvalid_q;

`ifdef UART_CSR_IRQ_EN
    logic irq_q;

    // Level interrupt registered from current state and enables
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) irq_q <= 1'b0;
        else           irq_q <= (rx_avail_q & ctrl_q[CTRL_IE_RX]) | (~tx_full & ctrl_q[CTRL_IE_TX]);
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule
